// File: rtl/debug_cmd_pkg.sv
// Shared widths, action-flag position and subcommand encodings for the
// system-clock-side debug command decoder.
package debug_cmd_pkg;

  localparam int unsigned IR_W_DEF        = 2;
  localparam int unsigned DR_W_DEF        = 38;
  localparam int unsigned SUB_W_DEF       = 2;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Channel numbers as decoded from the virtual IR
  localparam int unsigned CH_OCIMEM = 0;
  localparam int unsigned CH_TRACE  = 1;
  localparam int unsigned CH_BREAK  = 2;
  localparam int unsigned CH_CTRL   = 3;

  typedef enum logic [1:0] {
    OCIMEM_NOP       = 2'b00,
    OCIMEM_READ      = 2'b01,
    OCIMEM_WRITE     = 2'b10,
    OCIMEM_WRITE_INC = 2'b11
  } ocimem_sub_e;

  typedef enum logic [1:0] {
    BRK_NONE   = 2'b00,
    BRK_SET    = 2'b01,
    BRK_CLR    = 2'b10,
    BRK_RESUME = 2'b11
  } break_sub_e;

  // MSB of the shifted DR marks "take action"
  function automatic int unsigned act_bit(input int unsigned dr_w);
    return dr_w - 1;
  endfunction

endpackage

// File: rtl/debug_toggle_sync.sv
// Toggle synchroniser with post-reset guard and registered change detector;
// emits a one-cycle event per toggle of tgl_i.
module debug_toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tgl_i,
  output logic event_o
);

  localparam int unsigned GUARD = SYNC_STAGES + 2;
  localparam int unsigned CNT_W = $clog2(GUARD + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl_q, copy_q, evt_q, evt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   armed_c;

  assign armed_c = (cnt_q == CNT_W'(GUARD));

  // Until armed the copy follows the level, so a toggle held at reset is ignored
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tgl_i};
    evt_d  = armed_c & (lvl_q ^ copy_q);
    cnt_d  = armed_c ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      copy_q <= 1'b0;
      evt_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= sync_q[SYNC_STAGES-1];
      copy_q <= lvl_q;
      evt_q  <= evt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign event_o = evt_q;

endmodule

// File: rtl/debug_cmd_decoder.sv
// Debug slave command decoder: turns synchronised update-IR/update-DR events
// into per-channel valid/ready actions, no-action strobes and a status snapshot.
module debug_cmd_decoder
  import debug_cmd_pkg::*;
#(
  parameter  int unsigned IR_W        = IR_W_DEF,
  parameter  int unsigned DR_W        = DR_W_DEF,
  parameter  int unsigned SUB_W       = SUB_W_DEF,
  parameter  int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int unsigned N_CH        = 1 << IR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    udr_tgl,
  input  logic                    uir_tgl,
  input  logic [IR_W-1:0]         ir_in,
  input  logic [DR_W-1:0]         sr,
  output logic [DR_W-1:0]         jdo,
  output logic [N_CH-1:0]         act_valid,
  output logic [N_CH*SUB_W-1:0]   act_sub,
  input  logic [N_CH-1:0]         act_ready,
  output logic [N_CH-1:0]         noact_pulse,
  output logic [2*N_CH-1:0]       status,
  output logic [IR_W-1:0]         ir_q
);

  localparam int unsigned ACT_BIT = act_bit(DR_W);

  logic                  uir_evt, udr_evt;
  logic [IR_W-1:0]       ch_sel_c;
  logic                  act_flag_c;
  logic [SUB_W-1:0]      sub_c;

  logic [DR_W-1:0]       jdo_q, jdo_d;
  logic [N_CH-1:0]       valid_q, valid_d;
  logic [N_CH*SUB_W-1:0] sub_q, sub_d;
  logic [N_CH-1:0]       noact_q, noact_d;
  logic [N_CH-1:0]       ovf_q, ovf_d;
  logic [2*N_CH-1:0]     status_q, status_d;
  logic [IR_W-1:0]       ir_d;
  logic [N_CH-1:0]       accept_c;

  debug_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset   (reset),
    .tgl_i   (uir_tgl),
    .event_o (uir_evt)
  );

  debug_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset   (reset),
    .tgl_i   (udr_tgl),
    .event_o (udr_evt)
  );

  // A same-cycle IR update steers the DR command to the new channel
  assign ch_sel_c   = uir_evt ? ir_in : ir_q;
  assign act_flag_c = sr[ACT_BIT];
  assign sub_c      = sr[ACT_BIT-1 -: SUB_W];

  for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
    logic hit, rd_clr;
    assign hit    = udr_evt && (ch_sel_c == IR_W'(c));
    assign rd_clr = uir_evt && (ir_in == IR_W'(c));

    assign accept_c[c] = hit && act_flag_c && (!valid_q[c] || act_ready[c]);
    assign valid_d[c]  = accept_c[c] | (valid_q[c] & ~act_ready[c]);
    assign sub_d[c*SUB_W +: SUB_W] = accept_c[c] ? sub_c : sub_q[c*SUB_W +: SUB_W];
    assign noact_d[c]  = hit && !act_flag_c;
    // Set beats read-clear when both land in the same cycle
    assign ovf_d[c]    = (hit && act_flag_c && valid_q[c] && !act_ready[c])
                       | (ovf_q[c] & ~rd_clr);
  end

  always_comb begin
    jdo_d    = jdo_q;
    status_d = status_q;
    ir_d     = ir_q;
    if (udr_evt && (!act_flag_c || (|accept_c))) begin
      jdo_d = sr;
    end
    if (uir_evt) begin
      status_d = {ovf_q, valid_q};
      ir_d     = ir_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo_q    <= '0;
      valid_q  <= '0;
      sub_q    <= '0;
      noact_q  <= '0;
      ovf_q    <= '0;
      status_q <= '0;
      ir_q     <= '0;
    end else begin
      jdo_q    <= jdo_d;
      valid_q  <= valid_d;
      sub_q    <= sub_d;
      noact_q  <= noact_d;
      ovf_q    <= ovf_d;
      status_q <= status_d;
      ir_q     <= ir_d;
    end
  end

  assign jdo         = jdo_q;
  assign act_valid   = valid_q;
  assign act_sub     = sub_q;
  assign noact_pulse = noact_q;
  assign status      = status_q;

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// Self-checking bench for debug_cmd_decoder: directed scenarios plus random
// uir/udr traffic against a behavioural model of the command rules.
module tb_debug_cmd_decoder;

  localparam int unsigned IR_W  = 2;
  localparam int unsigned DR_W  = 38;
  localparam int unsigned SUB_W = 2;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned N_CH  = 4;
  localparam int          LAT   = SYNC + 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  udr_tgl, uir_tgl;
  logic [IR_W-1:0]       ir_in;
  logic [DR_W-1:0]       sr;
  logic [DR_W-1:0]       jdo;
  logic [N_CH-1:0]       act_valid;
  logic [N_CH*SUB_W-1:0] act_sub;
  logic [N_CH-1:0]       act_ready;
  logic [N_CH-1:0]       noact_pulse;
  logic [2*N_CH-1:0]     status;
  logic [IR_W-1:0]       ir_q;

  debug_cmd_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .udr_tgl     (udr_tgl),
    .uir_tgl     (uir_tgl),
    .ir_in       (ir_in),
    .sr          (sr),
    .jdo         (jdo),
    .act_valid   (act_valid),
    .act_sub     (act_sub),
    .act_ready   (act_ready),
    .noact_pulse (noact_pulse),
    .status      (status),
    .ir_q        (ir_q)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;
  bit rand_ready = 1'b0;

  // Model state: what the outputs must be after each edge
  logic [DR_W-1:0]       m_jdo;
  logic [N_CH-1:0]       m_valid, m_noact, m_ovf;
  logic [N_CH*SUB_W-1:0] m_sub;
  logic [2*N_CH-1:0]     m_status;
  logic [IR_W-1:0]       m_ir;
  int                    uir_sched[$];
  int                    udr_sched[$];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    n_cmp++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, x);
    end
  endtask

  task automatic model_reset();
    m_jdo = '0; m_valid = '0; m_noact = '0; m_ovf = '0;
    m_sub = '0; m_status = '0; m_ir = '0;
    uir_sched.delete();
    udr_sched.delete();
  endtask

  task automatic model_edge(input int e);
    logic          uev, dev;
    logic [N_CH-1:0] v0;
    int            c;
    if (reset) begin
      model_reset();
      return;
    end
    uev = 1'b0;
    dev = 1'b0;
    if (uir_sched.size() > 0 && uir_sched[0] == e) begin uev = 1'b1; void'(uir_sched.pop_front()); end
    if (udr_sched.size() > 0 && udr_sched[0] == e) begin dev = 1'b1; void'(udr_sched.pop_front()); end
    v0      = m_valid;
    m_noact = '0;
    m_valid = m_valid & ~act_ready;
    c = uev ? int'(ir_in) : int'(m_ir);
    if (uev) begin
      m_status     = {m_ovf, v0};
      m_ir         = ir_in;
      m_ovf[ir_in] = 1'b0;
    end
    if (dev) begin
      if (sr[DR_W-1]) begin
        if (!v0[c] || act_ready[c]) begin
          m_valid[c]             = 1'b1;
          m_sub[c*SUB_W +: SUB_W] = sr[DR_W-2 -: SUB_W];
          m_jdo                  = sr;
        end else begin
          m_ovf[c] = 1'b1;
        end
      end else begin
        m_noact[c] = 1'b1;
        m_jdo      = sr;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(cyc);
    cyc++;
    @(negedge clk);
    if (rand_ready) begin
      for (int i = 0; i < int'(N_CH); i++) act_ready[i] = ($urandom_range(0, 9) < 3);
    end
  endtask

  task automatic do_uir(input logic [IR_W-1:0] ir);
    ir_in   = ir;
    uir_tgl = ~uir_tgl;
    uir_sched.push_back(cyc + LAT);
  endtask

  task automatic do_udr(input logic [DR_W-1:0] v);
    sr      = v;
    udr_tgl = ~udr_tgl;
    udr_sched.push_back(cyc + LAT);
  endtask

  // Per-cycle comparison against the model, sampled after the edge settles
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("jdo",         64'(jdo),         64'(m_jdo));
      chk("act_valid",   64'(act_valid),   64'(m_valid));
      chk("act_sub",     64'(act_sub),     64'(m_sub));
      chk("noact_pulse", 64'(noact_pulse), 64'(m_noact));
      chk("status",      64'(status),      64'(m_status));
      chk("ir_q",        64'(ir_q),        64'(m_ir));
    end
  end

  initial begin
    logic [63:0] r;
    int          op;
    reset     = 1'b1;
    udr_tgl   = 1'b1;
    uir_tgl   = 1'b0;
    ir_in     = '0;
    sr        = '0;
    act_ready = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Toggle level held through reset must not produce an event
    repeat (20) tick();
    chk("rst_hold_jdo",   64'(jdo),       64'd0);
    chk("rst_hold_valid", 64'(act_valid), 64'd0);

    // Action on channel 2, latency and completion
    do_uir(2'd2);
    repeat (6) tick();
    do_udr({1'b1, 2'b01, 35'h5A5A});
    repeat (LAT) tick();
    chk("lat_early_valid2", 64'(act_valid[2]), 64'd0);
    tick();
    chk("lat_valid2", 64'(act_valid[2]), 64'd1);
    chk("lat_sub2",   64'(act_sub[5:4]), 64'd1);
    chk("lat_jdo",    64'(jdo),          64'h28_0000_5A5A);
    act_ready = 4'b0100;
    tick();
    act_ready = '0;
    chk("hs_valid2_low", 64'(act_valid[2]), 64'd0);

    // Overflow on channel 1 and read-to-clear status
    do_uir(2'd1);
    repeat (6) tick();
    do_udr({1'b1, 2'b10, 35'h111});
    repeat (6) tick();
    chk("ovf_first_valid", 64'(act_valid[1]), 64'd1);
    do_udr({1'b1, 2'b11, 35'h222});
    repeat (6) tick();
    chk("ovf_jdo_kept", 64'(jdo),          64'(38'h30_0000_0111));
    chk("ovf_sub_kept", 64'(act_sub[3:2]), 64'd2);
    do_uir(2'd1);
    repeat (6) tick();
    chk("ovf_status", 64'(status), 64'h22);
    do_uir(2'd1);
    repeat (6) tick();
    chk("ovf_cleared_status", 64'(status), 64'h02);
    act_ready = 4'b0010;
    tick();
    act_ready = '0;

    // New action in the same cycle as a completion keeps valid high
    do_uir(2'd0);
    repeat (6) tick();
    do_udr({1'b1, 2'b01, 35'h333});
    repeat (6) tick();
    do_udr({1'b1, 2'b11, 35'h444});
    repeat (LAT) tick();
    act_ready = 4'b0001;
    tick();
    act_ready = '0;
    chk("b2b_valid0", 64'(act_valid[0]), 64'd1);
    chk("b2b_sub0",   64'(act_sub[1:0]), 64'd3);
    chk("b2b_jdo",    64'(jdo),          64'(38'h38_0000_0444));
    repeat (2) tick();
    do_uir(2'd0);
    repeat (6) tick();
    chk("b2b_no_ovf_status", 64'(status), 64'h01);
    act_ready = 4'b0001;
    tick();
    act_ready = '0;

    // No-action command on channel 3
    do_uir(2'd3);
    repeat (6) tick();
    do_udr({1'b0, 2'b10, 35'h555});
    repeat (LAT) tick();
    chk("noact_early", 64'(noact_pulse), 64'd0);
    tick();
    chk("noact_pulse3", 64'(noact_pulse), 64'h8);
    chk("noact_jdo",    64'(jdo),         64'(38'h10_0000_0555));
    chk("noact_valid",  64'(act_valid),   64'd0);
    tick();
    chk("noact_once", 64'(noact_pulse), 64'd0);

    // Reset one cycle after a udr toggle drops the command
    do_udr({1'b1, 2'b01, 35'h666});
    tick();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_now_jdo",    64'(jdo),       64'd0);
    chk("rst_now_valid",  64'(act_valid), 64'd0);
    chk("rst_now_status", 64'(status),    64'd0);
    chk("rst_now_ir",     64'(ir_q),      64'd0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("rst_mid_valid", 64'(act_valid), 64'd0);
    chk("rst_mid_jdo",   64'(jdo),       64'd0);

    // Random traffic, including simultaneous uir+udr
    rand_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      op = int'($urandom_range(0, 3));
      if (op == 0 || op == 3) do_uir(IR_W'($urandom_range(0, N_CH - 1)));
      if (op != 0) begin
        r = {$urandom(), $urandom()};
        r[DR_W-1] = ($urandom_range(0, 9) < 7);
        do_udr(r[DR_W-1:0]);
      end
      repeat ($urandom_range(5, 9)) tick();
    end
    rand_ready = 1'b0;
    act_ready  = '0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
